// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding, alignment constant and default widths.
package cpu_pkg;
  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;
  localparam logic [1:0] ALIGN_OK = 2'b00;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != ALIGN_OK;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Memory request/response and decode handshake bundle for the fetch stage.
interface fetch_unit_if import cpu_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();
  // valid/ready: a transfer happens on a rising edge where both are 1; the
  // sender keeps valid and payload stable until then. rsp_valid has no ready.
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_fault;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
endinterface

// File: rtl/fetch_hold_reg.sv
// Holding register for the word, address and fault flag presented to decode.
module fetch_hold_reg import cpu_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cap_pc_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               fault_i,
  input  logic               cap_data_i,
  input  logic [INSTR_W-1:0] data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_fault_o
);
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               fault_q;

  // Capturing the address also zeroes the word so a faulting fetch shows instr=0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else if (cap_pc_i) begin
      instr_q <= '0;
      pc_q    <= pc_i;
      fault_q <= fault_i;
    end else if (cap_data_i) begin
      instr_q <= data_i;
    end
  end

  assign instr_o       = instr_q;
  assign instr_pc_o    = pc_q;
  assign instr_fault_o = fault_q;
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/HOLD).
// Optional FETCH_STALL_COUNT_EN adds the stall_cycles counter port.
module fetch_unit import cpu_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  output logic              pc_stall,
  input  logic              flush,
  fetch_unit_if.master      bus,
  output fetch_state_e      dbg_state_o
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  fetch_state_e state_q;
  logic         drop_q;
  logic         misaligned;
  logic         in_req;
  logic         cap_pc;
  logic         rsp_take;

  assign misaligned = is_misaligned(pc_current[1:0]);
  assign in_req     = (state_q == ST_REQ);
  // A misaligned PC skips the memory and goes straight to HOLD as a fault.
  assign cap_pc     = in_req && (misaligned || bus.imem_req_ready);
  assign rsp_take   = (state_q == ST_WAIT) && bus.imem_rsp_valid && !drop_q && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (cap_pc) state_q <= misaligned ? ST_HOLD : ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_q <= (drop_q || flush) ? ST_REQ : ST_HOLD;
            drop_q  <= 1'b0;
          end else if (flush) begin
            drop_q  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (flush || bus.instr_ready) state_q <= ST_REQ;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_hold_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_hold (
    .clock         (clock),
    .reset         (reset),
    .cap_pc_i      (cap_pc),
    .pc_i          (pc_current),
    .fault_i       (misaligned),
    .cap_data_i    (rsp_take),
    .data_i        (bus.imem_rsp_data),
    .instr_o       (bus.instr),
    .instr_pc_o    (bus.instr_pc),
    .instr_fault_o (bus.instr_fault)
  );

  assign bus.imem_req_valid = in_req && !misaligned;
  assign bus.imem_req_addr  = in_req ? pc_current : '0;
  assign bus.instr_valid    = (state_q == ST_HOLD);
  assign pc_stall           = !((state_q == ST_HOLD) && bus.instr_ready && !flush);
  assign dbg_state_o        = state_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q != ST_IDLE) && pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the PC and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 32, SHALL set the instruction word width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset (asserted when 0).
REQ-005 pc_current  input  ADDR_W  SHALL carry the address of the next instruction from the program counter.
REQ-006 pc_stall  output  1  SHALL hold the program counter when 1.
REQ-007 flush  input  1  SHALL discard any in-flight or held instruction (redirect).
REQ-008 imem_req_valid / imem_req_ready  output / input  1 / 1  SHALL form the memory request handshake.
REQ-009 imem_req_addr  output  ADDR_W  SHALL carry the request address.
REQ-010 imem_rsp_valid / imem_rsp_data  input / input  1 / INSTR_W  SHALL carry the memory response.
REQ-011 instr_valid / instr_ready  output / input  1 / 1  SHALL form the handshake to decode.
REQ-012 instr / instr_pc / instr_fault  output  INSTR_W / ADDR_W / 1  SHALL carry the fetched word, its address, and the misalignment flag.

Function
REQ-013 The FSM SHALL have exactly four states, IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-014 IDLE: all outputs 0 and pc_stall=1; the first cycle after reset release SHALL go to REQ.
REQ-015 REQ: imem_req_valid=1 and imem_req_addr=pc_current, captured into instr_pc; valid&ready SHALL go to WAIT; the address SHALL stay stable while ready=0.
REQ-016 REQ with pc_current[1:0]!=0: no request SHALL be issued; the FSM SHALL go to HOLD with instr_fault=1 and instr=0.
REQ-017 WAIT: imem_rsp_valid SHALL register imem_rsp_data into instr and go to HOLD; minimum fetch latency is 2 cycles from entering REQ to instr_valid.
REQ-018 HOLD: instr_valid=1 with instr, instr_pc and instr_fault stable; instr_valid&instr_ready SHALL go to REQ.
REQ-019 pc_stall SHALL be 0 only in the cycle HOLD && instr_ready && !flush; the PC therefore advances exactly once per consumed instruction.
REQ-020 Flush in REQ SHALL change nothing; the address re-samples pc_current.
REQ-021 Flush in WAIT SHALL set a drop flag; the next response, including one in the same cycle as flush, SHALL be discarded, followed by a return to REQ.
REQ-022 Flush in HOLD SHALL clear instr_valid on the next cycle and return to REQ, regardless of instr_ready.
REQ-023 imem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-024 Asserting reset at any time, including mid-transaction, SHALL immediately force IDLE, clear the drop flag, and drive all outputs to 0 except pc_stall=1.
REQ-025 A response arriving after reset release for a request issued before reset SHALL be ignored (REQ-023).

Configuration
REQ-026 With FETCH_STALL_COUNT_EN defined, output stall_cycles [31:0] SHALL count cycles with pc_stall=1 outside IDLE, saturate at 0xFFFFFFFF, and reset to 0.
REQ-027 Without FETCH_STALL_COUNT_EN, the port and counter SHALL not exist.

Structure
REQ-028 The FSM state enum, the misalign check constant (2'b00) and the default widths SHALL live in shared package cpu_pkg.
REQ-029 The instr/instr_pc/instr_fault holding register SHALL be a sub-module fetch_hold_reg.

Verification
REQ-030 Reset release, pc_current=0x0, ready=1, response 0x00500093 one cycle later -> instr_valid in cycle 3, instr=0x00500093, instr_pc=0x0.
REQ-031 ready held 0 for 3 cycles -> imem_req_addr constant and pc_stall=1 throughout.
REQ-032 pc_current=0x6 -> no imem_req_valid; instr_valid=1, instr_fault=1, instr=0.
REQ-033 Flush in WAIT, response 0xDEADBEEF -> never presented; next request uses the new pc_current=0x100.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> outputs stable, pc_stall=1; with FETCH_STALL_COUNT_EN, stall_cycles increments by 5.
REQ-035 reset asserted in WAIT -> outputs 0 next edge; a subsequent imem_rsp_valid is ignored.
